mult_div_ctrl: RTL and testbench



---
 rtl/mult_div_ctrl.sv | 131 +++++++++++++
 tb/tb_mult_div_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_ctrl.sv
// Iterative 32x32 signed shift-add multiplier and restoring divider feeding the Hi/Lo registers.
// Optional macro MD_DIV_ZERO_TRAP_EN short-circuits divide-by-zero and raises div_zero.
module mult_div_ctrl (
  input  logic        clock,
  input  logic        reset,
  input  logic        start_mult,
  input  logic        start_div,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t                  state;
  logic [4:0]              cnt;
  logic                    op_div;
  logic                    sign_a;
  logic                    sign_b;
  logic [DATA_W-1:0]       opnd;
  logic [2*DATA_W-1:0]     acc;
  logic [DATA_W:0]         add_sum;
  logic [DATA_W:0]         sub_diff;
  logic [2*DATA_W-1:0]     acc_shl;
  logic                    neg_res;
  logic                    trap_hit;

  function automatic logic [DATA_W-1:0] abs_w(input logic signed [DATA_W-1:0] v);
    logic signed [DATA_W-1:0] n;
    n = -v;
    return v[DATA_W-1] ? DATA_W'(n) : DATA_W'(v);
  endfunction

  function automatic logic [DATA_W-1:0] neg_w(input logic [DATA_W-1:0] v);
    return ~v + 1'b1;
  endfunction

  function automatic logic [2*DATA_W-1:0] neg_dw(input logic [2*DATA_W-1:0] v);
    return ~v + 1'b1;
  endfunction

  assign add_sum  = {1'b0, acc[2*DATA_W-1:DATA_W]} + {1'b0, opnd};
  assign acc_shl  = {acc[2*DATA_W-2:0], 1'b0};
  assign sub_diff = {1'b0, acc_shl[2*DATA_W-1:DATA_W]} - {1'b0, opnd};
  assign neg_res  = sign_a ^ sign_b;

`ifdef MD_DIV_ZERO_TRAP_EN
  assign trap_hit = (b == '0);
`else
  assign trap_hit = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt      <= '0;
          done     <= 1'b0;
          div_zero <= 1'b0;
          if (start_mult) begin
            op_div <= 1'b0;
            sign_a <= a[DATA_W-1];
            sign_b <= b[DATA_W-1];
            opnd   <= abs_w(a);
            acc    <= {{DATA_W{1'b0}}, abs_w(b)};
            busy   <= 1'b1;
            state  <= CALC;
          end else if (start_div) begin
            op_div <= 1'b1;
            sign_a <= a[DATA_W-1];
            sign_b <= b[DATA_W-1];
            opnd   <= abs_w(b);
            acc    <= {{DATA_W{1'b0}}, abs_w(a)};
            busy   <= 1'b1;
            if (trap_hit) begin
              // Hi/Lo are left untouched on a trapped divide
              done     <= 1'b1;
              div_zero <= 1'b1;
              state    <= DONE;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (!op_div) begin
            acc <= acc[0] ? {add_sum, acc[DATA_W-1:1]} : {1'b0, acc[2*DATA_W-1:1]};
          end else begin
            // Borrow out of the trial subtract means restore the shifted remainder
            acc <= sub_diff[DATA_W] ? acc_shl
                                    : {sub_diff[DATA_W-1:0], acc_shl[DATA_W-1:1], 1'b1};
          end
          if (cnt == 5'd31) state <= FIX;
          else              cnt   <= cnt + 5'd1;
        end
        FIX: begin
          if (!op_div) begin
            {hi, lo} <= neg_res ? neg_dw(acc) : acc;
          end else begin
            lo <= neg_res ? neg_w(acc[DATA_W-1:0]) : acc[DATA_W-1:0];
            hi <= sign_a  ? neg_w(acc[2*DATA_W-1:DATA_W]) : acc[2*DATA_W-1:DATA_W];
          end
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          done     <= 1'b0;
          div_zero <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Bench for mult_div_ctrl: vector table plus corner sequences, results checked through a scoreboard.
module tb_mult_div_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        start_mult;
  logic        start_div;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  mult_div_ctrl dut (
    .clock(clock), .reset(reset), .start_mult(start_mult), .start_div(start_div),
    .a(a), .b(b), .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] h;
    logic [31:0] l;
    logic        dz;
    int          lat;
  } exp_t;

  // mode: 0 multiply, 1 divide, 2 both starts together
  typedef struct {
    int          mode;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] h;
    logic [31:0] l;
  } vec_t;

  int          checks;
  int          errors;
  exp_t        sb[$];
  vec_t        vecs[10];
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input bit is_div, input logic [31:0] av, input logic [31:0] bv);
    exp_t   e;
    longint sa, sb2, p;
    int     ia, ib;
    e.dz  = 1'b0;
    e.lat = 34;
    if (!is_div) begin
      sa  = $signed(av);
      sb2 = $signed(bv);
      p   = sa * sb2;
      e.h = p[63:32];
      e.l = p[31:0];
    end else if (bv == 32'h0) begin
`ifdef MD_DIV_ZERO_TRAP_EN
      e.h = m_hi; e.l = m_lo; e.dz = 1'b1; e.lat = 1;
`else
      e.h = av; e.l = av[31] ? 32'h1 : 32'hFFFF_FFFF;
`endif
    end else if (av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) begin
      e.h = 32'h0; e.l = 32'h8000_0000;
    end else begin
      ia  = $signed(av);
      ib  = $signed(bv);
      e.l = ia / ib;
      e.h = ia % ib;
    end
    return e;
  endfunction

  // Drive a start for one cycle starting at the current negedge
  task automatic issue(input int mode, input logic [31:0] av, input logic [31:0] bv,
                       input bit push, input exp_t e);
    start_mult = (mode != 1);
    start_div  = (mode != 0);
    a = av;
    b = bv;
    if (push) sb.push_back(e);
    @(negedge clock);
    start_mult = 1'b0;
    start_div  = 1'b0;
  endtask

  task automatic finish_op(input string tag, input int inject_at);
    int   n;
    int   nb;
    exp_t e;
    n  = 1;
    nb = 0;
    while (!done && n < 60) begin
      if (busy) nb++;
      start_div = (n == inject_at);
      @(negedge clock);
      n++;
    end
    start_div = 1'b0;
    if (busy) nb++;
    if (sb.size() == 0) begin
      chk({tag, "_scoreboard_empty"}, 32'(sb.size()), 32'd1);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_latency"}, 32'(n), 32'(e.lat));
    chk({tag, "_busy_cycles"}, 32'(nb), 32'(e.lat));
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_hi"}, hi, e.h);
    chk({tag, "_lo"}, lo, e.l);
    chk({tag, "_div_zero"}, 32'(div_zero), 32'(e.dz));
    m_hi = e.h;
    m_lo = e.l;
    @(negedge clock);
    chk({tag, "_busy_after"}, 32'(busy), 32'd0);
    chk({tag, "_done_after"}, 32'(done), 32'd0);
  endtask

  initial begin
    exp_t        e;
    int          extra;
    logic [31:0] ra, rb;
    bit          rdiv;

    checks = 0; errors = 0;
    m_hi = 32'h0; m_lo = 32'h0;
    vecs[0] = '{0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[1] = '{1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[2] = '{1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[3] = '{2, 32'h0000_0005, 32'h0000_0006, 32'h0000_0000, 32'h0000_001E};
    vecs[4] = '{0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[5] = '{0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
    vecs[6] = '{1, 32'h0000_0064, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFF2};
    vecs[7] = '{1, 32'hFFFF_FF9C, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFF2};
    vecs[8] = '{0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000};
    vecs[9] = '{1, 32'h0000_2211, 32'h0000_0100, 32'h0000_0011, 32'h0000_0022};

    reset = 1'b1; start_mult = 1'b0; start_div = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_div_zero", 32'(div_zero), 32'd0);
    chk("reset_hi", hi, 32'h0);
    chk("reset_lo", lo, 32'h0);

    foreach (vecs[i]) begin
      e.h = vecs[i].h; e.l = vecs[i].l; e.dz = 1'b0; e.lat = 34;
      issue(vecs[i].mode, vecs[i].a, vecs[i].b, 1'b1, e);
      finish_op($sformatf("vec%0d", i), -1);
    end

    // Divide by zero after Hi/Lo = 0x11/0x22
`ifdef MD_DIV_ZERO_TRAP_EN
    e = '{32'h11, 32'h22, 1'b1, 1};
`else
    e = '{32'h7, 32'hFFFF_FFFF, 1'b0, 34};
`endif
    issue(1, 32'h7, 32'h0, 1'b1, e);
    finish_op("div0_pos", -1);
    issue(1, 32'hFFFF_FFF9, 32'h0, 1'b1, model(1'b1, 32'hFFFF_FFF9, 32'h0));
    finish_op("div0_neg", -1);

    // start_div pulse in cycle k+10 of a multiply must be ignored
    issue(0, 32'h0000_0009, 32'h0000_000B, 1'b1, model(1'b0, 32'h9, 32'hB));
    finish_op("arb_inject", 10);
    extra = 0;
    repeat (40) begin
      if (done) extra++;
      @(negedge clock);
    end
    chk("arb_extra_done", 32'(extra), 32'd0);

    // Reset in cycle k+15 discards the multiply
    issue(0, 32'h1234, 32'h5678, 1'b0, e);
    repeat (14) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("midreset_busy", 32'(busy), 32'd0);
    chk("midreset_done", 32'(done), 32'd0);
    chk("midreset_hi", hi, 32'h0);
    chk("midreset_lo", lo, 32'h0);
    m_hi = 32'h0; m_lo = 32'h0;
    issue(1, 32'd1000, 32'd33, 1'b1, model(1'b1, 32'd1000, 32'd33));
    finish_op("after_reset", -1);

    for (int i = 0; i < 10; i++) begin
      ra   = $urandom;
      rb   = $urandom;
      rdiv = $urandom_range(0, 1);
      if (rb == 32'h0) rb = 32'h1;
      issue(rdiv ? 1 : 0, ra, rb, 1'b1, model(rdiv, ra, rb));
      finish_op($sformatf("rand%0d", i), -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
